// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that queues write/read commands in a FIFO and issues them one at a time,
// returning one response per command (data, RRESP/BRESP, timeout flag).
module axil_cmd_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    input  logic [1:0]        m_bresp_i,
    input  logic              m_bvalid_i,
    output logic              m_bready_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    output logic [2:0]        state_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_AW_W = 3'd1;
    localparam logic [2:0] S_WR_B    = 3'd2;
    localparam logic [2:0] S_RD_AR   = 3'd3;
    localparam logic [2:0] S_RD_R    = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              fifo_empty, fifo_full, push, pop;
    logic [ENT_W-1:0]  head;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;

    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, active, done, tmo;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = cmd_valid_i && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    assign hs_aw  = awvalid_q && m_awready_i;
    assign hs_w   = wvalid_q && m_wready_i;
    assign hs_b   = bready_q && m_bvalid_i;
    assign hs_ar  = arvalid_q && m_arready_i;
    assign hs_r   = rready_q && m_rvalid_i;
    assign active = (state_q == S_WR_AW_W) || (state_q == S_WR_B) ||
                    (state_q == S_RD_AR) || (state_q == S_RD_R);
    assign done   = ((state_q == S_WR_B) && hs_b) || ((state_q == S_RD_R) && hs_r);
    // The timer is loaded with 1 on pop so it counts the pop cycle; abandoning at
    // TIMEOUT-1 puts rsp_valid exactly TIMEOUT cycles after the pop.
    assign tmo    = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {cmd_we_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        timer_d     = timer_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        if (active) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    addr_d    = head[ENT_W-2 -: ADDR_W];
                    wdata_d   = head[DATA_W-1:0];
                    timer_d   = TMR_W'(1);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (head[ENT_W-1]) begin
                        state_d   = S_WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR_AW_W: begin
                if (hs_aw) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (hs_w) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || hs_aw) && (w_done_q || hs_w)) begin
                    state_d  = S_WR_B;
                    bready_d = 1'b1;
                end
            end
            S_WR_B: begin
                if (hs_b) begin
                    bready_d    = 1'b0;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_bresp_i;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            S_RD_AR: begin
                if (hs_ar) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (hs_r) begin
                    rready_d    = 1'b0;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_rresp_i;
                    rsp_rdata_d = m_rdata_i;
                    rsp_err_d   = 1'b0;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_resp_d  = 2'b00;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A final handshake landing on the timeout cycle still counts as a normal completion.
        if (active && tmo && !done) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready_o = !fifo_full;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_resp_o  = rsp_resp_q;
    assign rsp_err_o   = rsp_err_q;
    assign m_awvalid_o = awvalid_q;
    assign m_awaddr_o  = awvalid_q ? addr_q : '0;
    assign m_wvalid_o  = wvalid_q;
    assign m_wdata_o   = wvalid_q ? wdata_q : '0;
    assign m_bready_o  = bready_q;
    assign m_arvalid_o = arvalid_q;
    assign m_araddr_o  = arvalid_q ? addr_q : '0;
    assign m_rready_o  = rready_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed vector table against a configurable AXI-Lite slave,
// plus hand sequences for backpressure, timeout, response hold and mid-transaction reset.
module tb_axil_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [2:0]  state_dbg;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;

    axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_resp_o(rsp_resp), .rsp_err_o(rsp_err),
        .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
        .m_wdata_o(m_wdata), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
        .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
        .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
        .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
        .state_o(state_dbg)
    );

    // Slave configuration, written only by the test sequence.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          aw_stall = 1'b0, b_never = 1'b0, slv_clr = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    // Slave state and handshake log, written only by the slave process.
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    logic        l_awv = 1'b0, l_wv = 1'b0, l_arv = 1'b0, l_bready = 1'b0, l_rready = 1'b0;
    logic [31:0] l_awaddr = '0, l_wdata = '0, l_araddr = '0;

    // Slave runs on the falling edge: first records handshakes of the previous rising edge,
    // then drives its outputs for the next one.
    always @(negedge clk) begin
        if (rst || slv_clr) begin
            m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
            m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
            l_awv = 1'b0; l_wv = 1'b0; l_arv = 1'b0; l_bready = 1'b0; l_rready = 1'b0;
        end else begin
            if (l_awv && m_awready) begin aw_hs++; aw_pend = 1'b1; aw_log.push_back(l_awaddr); end
            if (l_wv && m_wready) begin w_hs++; w_pend = 1'b1; w_log.push_back(l_wdata); end
            if (l_arv && m_arready) begin ar_hs++; ar_pend = 1'b1; ar_log.push_back(l_araddr); end
            if (l_bready && m_bvalid) begin
                m_bvalid = 1'b0; aw_pend = 1'b0; w_pend = 1'b0; b_cnt = 0;
            end
            if (l_rready && m_rvalid) begin
                m_rvalid = 1'b0; ar_pend = 1'b0; r_cnt = 0; m_rdata = '0;
            end

            m_awready = m_awvalid && !aw_stall && (aw_cnt >= aw_dly);
            if (!m_awvalid) aw_cnt = 0; else if (!m_awready) aw_cnt++;
            m_wready = m_wvalid && (w_cnt >= w_dly);
            if (!m_wvalid) w_cnt = 0; else if (!m_wready) w_cnt++;
            m_arready = m_arvalid && (ar_cnt >= ar_dly);
            if (!m_arvalid) ar_cnt = 0; else if (!m_arready) ar_cnt++;

            if (aw_pend && w_pend && !m_bvalid && !b_never) begin
                if (b_cnt >= b_dly) begin m_bvalid = 1'b1; m_bresp = cfg_bresp; end
                else b_cnt++;
            end
            if (ar_pend && !m_rvalid) begin
                if (r_cnt >= r_dly) begin m_rvalid = 1'b1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; end
                else r_cnt++;
            end

            l_awv = m_awvalid; l_awaddr = m_awaddr;
            l_wv = m_wvalid; l_wdata = m_wdata;
            l_arv = m_arvalid; l_araddr = m_araddr;
            l_bready = m_bready; l_rready = m_rready;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // lat = number of falling edges until rsp_valid is seen; 0 means it never arrived.
    task automatic get_rsp(output logic [31:0] d, output logic [1:0] r, output logic e, output int lat);
        bit got;
        got = 1'b0; lat = 0; d = '0; r = 2'b00; e = 1'b0;
        for (int n = 1; n <= 300 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = n;
                d = rsp_rdata; r = rsp_resp; e = rsp_err;
                rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] last_of(input logic [31:0] q[$]);
        return (q.size() > 0) ? q[q.size()-1] : 32'hFFFF_FFFF;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, hd;
        logic [1:0]  r, hr;
        logic        e;
        int          lat, aw0, w0, ar0, acc, bad, base;
        bit          got, rdy_at_10th;

        vecs[0] = '{we:1'b1, addr:32'h43C0001C, wdata:32'h80000000, aw_dly:0, w_dly:2, b_dly:1,
                    ar_dly:0, r_dly:0, slv_resp:2'b00, slv_rdata:32'h0, exp_rdata:32'h0,
                    exp_resp:2'b00, exp_lat:7};
        vecs[1] = '{we:1'b0, addr:32'h43C00020, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0,
                    ar_dly:0, r_dly:0, slv_resp:2'b00, slv_rdata:32'h000000FF, exp_rdata:32'h000000FF,
                    exp_resp:2'b00, exp_lat:4};
        vecs[2] = '{we:1'b1, addr:32'h43C00008, wdata:32'h0000_00A5, aw_dly:3, w_dly:0, b_dly:0,
                    ar_dly:0, r_dly:0, slv_resp:2'b10, slv_rdata:32'h0, exp_rdata:32'h0,
                    exp_resp:2'b10, exp_lat:7};
        vecs[3] = '{we:1'b0, addr:32'h43C00104, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0,
                    ar_dly:2, r_dly:3, slv_resp:2'b11, slv_rdata:32'hDEADBEEF, exp_rdata:32'hDEADBEEF,
                    exp_resp:2'b11, exp_lat:9};
        vecs[4] = '{we:1'b0, addr:32'h00000010, wdata:32'h0, aw_dly:0, w_dly:0, b_dly:0,
                    ar_dly:0, r_dly:0, slv_resp:2'b01, slv_rdata:32'h12345678, exp_rdata:32'h12345678,
                    exp_resp:2'b01, exp_lat:4};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_axi_valids", {27'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'd0);
        check("rst_rsp", {29'd0, rsp_valid, rsp_err, 1'b0} | {30'd0, rsp_resp}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_addr_data", m_awaddr | m_wdata | m_araddr, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly; b_dly = vecs[i].b_dly;
            ar_dly = vecs[i].ar_dly; r_dly = vecs[i].r_dly;
            cfg_bresp = vecs[i].slv_resp; cfg_rresp = vecs[i].slv_resp; cfg_rdata = vecs[i].slv_rdata;
            aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
            push(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            get_rsp(d, r, e, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("v%0d_resp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
            check($sformatf("v%0d_err", i), {31'd0, e}, 32'd0);
            check($sformatf("v%0d_aw_hs", i), 32'(aw_hs - aw0), vecs[i].we ? 32'd1 : 32'd0);
            check($sformatf("v%0d_w_hs", i), 32'(w_hs - w0), vecs[i].we ? 32'd1 : 32'd0);
            check($sformatf("v%0d_ar_hs", i), 32'(ar_hs - ar0), vecs[i].we ? 32'd0 : 32'd1);
            if (vecs[i].we) begin
                check($sformatf("v%0d_awaddr", i), last_of(aw_log), vecs[i].addr);
                check($sformatf("v%0d_wdata", i), last_of(w_log), vecs[i].wdata);
            end else begin
                check($sformatf("v%0d_araddr", i), last_of(ar_log), vecs[i].addr);
            end
        end

        // Backpressure: awready stalled, 10 back-to-back pushes
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; cfg_bresp = 2'b00;
        aw_stall = 1'b1; acc = 0; rdy_at_10th = 1'b1; base = aw_log.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_we = 1'b1;
            cmd_addr = 32'h0000_1000 + 32'(acc * 4); cmd_wdata = 32'(acc);
            if (i == 9) rdy_at_10th = cmd_ready;
            if (cmd_ready) acc++;
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        aw_stall = 1'b0;
        check("bp_accepted", 32'(acc), 32'd9);
        check("bp_ready_low_10th", {31'd0, rdy_at_10th}, 32'd0);
        for (int k = 0; k < 9; k++) begin
            get_rsp(d, r, e, lat);
            check($sformatf("bp_rsp%0d_seen_ok", k), {31'd0, (lat != 0) && !e}, 32'd1);
        end
        for (int k = 0; k < 9; k++) begin
            check($sformatf("bp_order%0d", k),
                  (aw_log.size() > base + k) ? aw_log[base + k] : 32'hFFFF_FFFF,
                  32'h0000_1000 + 32'(k * 4));
        end

        // Timeout: bvalid never comes, queued read then completes normally
        b_never = 1'b1; cfg_rdata = 32'hA5A5A5A5; cfg_rresp = 2'b00;
        push(1'b1, 32'h43C00040, 32'h1);
        push(1'b0, 32'h43C00044, 32'h0);
        get_rsp(d, r, e, lat);
        check("tmo_latency", 32'(lat), 32'd16);
        check("tmo_err", {31'd0, e}, 32'd1);
        check("tmo_resp", {30'd0, r}, 32'd2);
        check("tmo_rdata", d, 32'd0);
        get_rsp(d, r, e, lat);
        check("after_tmo_seen", {31'd0, lat != 0}, 32'd1);
        check("after_tmo_rdata", d, 32'hA5A5A5A5);
        check("after_tmo_err_resp", {29'd0, e, r}, 32'd0);
        b_never = 1'b0;
        @(posedge clk); slv_clr = 1'b1;
        @(posedge clk); slv_clr = 1'b0;

        // Response held off while commands are queued
        cfg_rresp = 2'b01; cfg_rdata = 32'h11112222;
        ar0 = ar_hs;
        push(1'b0, 32'h43C00030, 32'h0);
        push(1'b0, 32'h43C00034, 32'h0);
        push(1'b1, 32'h43C00038, 32'h77);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check("hold_rsp_seen", {31'd0, got}, 32'd1);
        hd = rsp_rdata; hr = rsp_resp; bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== hd || rsp_resp !== hr || m_arvalid || m_awvalid) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        check("hold_rdata", hd, 32'h11112222);
        check("hold_single_ar", 32'(ar_hs - ar0), 32'd1);
        cfg_rdata = 32'h33334444; cfg_rresp = 2'b00;
        get_rsp(d, r, e, lat);
        check("hold_rsp0", {d[29:0], r}, {30'h11112222 & 30'h3FFFFFFF, 2'b01});
        get_rsp(d, r, e, lat);
        check("hold_rsp1_rdata", d, 32'h33334444);
        get_rsp(d, r, e, lat);
        check("hold_rsp2_write", {lat != 0, e, r, d[27:0]}, {1'b1, 31'd0});

        // Reset while waiting in RD_R
        r_dly = 30;
        push(1'b0, 32'h43C00020, 32'h0);
        push(1'b1, 32'h43C00024, 32'h5);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (m_rready) got = 1'b1;
        end
        check("rst_mid_reached_rd_r", {31'd0, got}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_arvalid_rready", {30'd0, m_arvalid, m_rready}, 32'd0);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        r_dly = 0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_awvalid || m_arvalid || rsp_valid) bad++;
        end
        check("rst_mid_fifo_empty", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
